// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch controller: PC, big-endian capture, valid/ready output slot
module fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [15:0]       imem_addr,
    input  logic [15:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [15:0]       inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       retired
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic [15:0]       inst_out_q, inst_out_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [15:0]       retired_q, retired_d;

    logic              slot_free;
    logic              handshake;
    logic [ADDR_W-1:0] target_pc;

    assign slot_free = !inst_valid_q || inst_ready;
    assign handshake = inst_valid_q && inst_ready;
    assign target_pc = redirect_pc & ~ADDR_W'(1);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        retired_d    = retired_q;

        // Handshakes count in every state, including one whose instruction is being flushed.
        if (handshake && (retired_q != 16'hFFFF)) begin
            retired_d = retired_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_d = target_pc;
                end
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_d         = target_pc;
                    inst_valid_d = 1'b0;
                end else if (halt_req) begin
                    if (inst_ready) begin
                        inst_valid_d = 1'b0;
                    end
                    state_d = S_DRAIN;
                end else if (slot_free) begin
                    inst_out_d   = imem_data;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + ADDR_W'(2);
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    pc_d         = target_pc;
                    inst_valid_d = 1'b0;
                    state_d      = S_HALT;
                end else begin
                    if (inst_ready) begin
                        inst_valid_d = 1'b0;
                    end
                    if (slot_free) begin
                        state_d = S_HALT;
                    end
                end
            end
            default: begin
                inst_valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d    = target_pc;
                    state_d = S_FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_out_q   <= 16'd0;
            inst_pc_q    <= '0;
            retired_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            retired_q    <= retired_d;
        end
    end

    assign imem_addr  = 16'(pc_q);
    assign inst_valid = inst_valid_q;
    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;
    assign busy       = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign halted     = (state_q == S_HALT);
    assign retired    = retired_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller sitting between the core and the byte-addressed instruction memory. Owns the program counter, drives the memory's 16-bit fetch address, and captures the returned big-endian 16-bit instruction into a one-deep output register. That register is handed to decode over a valid/ready handshake. Supports start, stall via back-pressure, branch/jump redirect with flush, and halt with drain.

## Interface
Parameters:
- ADDR_W, 8, PC width in bits; instruction memory spans 2^ADDR_W bytes.
- RESET_PC, 0, PC value loaded on reset (must be even).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- run  in  1  start fetching; sampled only in IDLE.
- imem_addr  out  16  byte address to the instruction memory; PC zero-extended to 16 bits.
- imem_data  in  16  instruction returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_W  target address; bit 0 forced to 0.
- halt_req  in  1  stop fetching after draining.
- inst_valid  out  1  inst_out/inst_pc hold a valid instruction.
- inst_ready  in  1  decode accepts the instruction this cycle.
- inst_out  out  16  captured instruction.
- inst_pc  out  ADDR_W  byte address inst_out was fetched from.
- busy  out  1  state is FETCH or DRAIN.
- halted  out  1  state is HALT.
- retired  out  16  count of completed handshakes (inst_valid && inst_ready); saturates at 0xFFFF.

## Operation
States: IDLE, FETCH, DRAIN, HALT.

- **Reset values:**
  - state IDLE; pc = RESET_PC, so imem_addr = RESET_PC.
  - inst_valid = 0, inst_out = 0, inst_pc = 0.
  - busy = 0, halted = 0, retired = 0.
- **imem_addr** is always pc, a registered value, never combinational from inputs.
- **slot_free** = !inst_valid || inst_ready.
- **IDLE:**
  - run = 1 → FETCH.
  - redirect_valid in IDLE loads pc and stays in IDLE.
- **FETCH:** priority order, first match wins.
  1. redirect_valid: pc ← {redirect_pc[ADDR_W-1:1],0}; inst_valid ← 0 (flush, even if inst_ready); no capture; stay in FETCH. A flushed instruction accepted this same cycle still counts in retired.
  2. halt_req: no capture; pc holds; → DRAIN.
  3. slot_free: inst_out ← imem_data, inst_pc ← pc, inst_valid ← 1, pc ← pc + 2 (mod 2^ADDR_W).
  4. otherwise stall: pc and output register hold.
- **DRAIN:**
  - No new captures.
  - If inst_ready, inst_valid ← 0.
  - When inst_valid = 0, or is being cleared this cycle → HALT.
  - redirect_valid in DRAIN: flush, load pc, → HALT.
- **HALT:**
  - halted = 1, inst_valid = 0.
  - redirect_valid: load pc → FETCH. Leaving HALT otherwise requires reset.
  - run is ignored.
- **PC wrap:** pc = 2^ADDR_W − 2 increments to 0.
- **retired:** increments on every handshake in any state; holds at 0xFFFF.

## Timing
- Capture latency: run sampled at edge k enters FETCH. The first capture happens at edge k+1, so inst_valid = 1 after k+1 with inst_pc = RESET_PC.
- Throughput: one instruction per cycle while inst_ready = 1 continuously.
- Stall: inst_ready = 0 with inst_valid = 1 holds inst_out, inst_pc, and pc stable; no instruction is lost or duplicated.
- Redirect: asserted before edge r, inst_valid = 0 after r. The target instruction is valid after r+1 (one bubble).
- Halt: asserted at edge h with slot empty or draining gives halted = 1 after edge h+1 at latest. Otherwise it waits on inst_ready.
- Asynchronous reset mid-operation returns all outputs to reset values without waiting for clk. The first fetch after reset release requires run again.

## Test plan
Memory image: 0x00:0x31,0x12; 0x02:0x34,0x13; 0x04:0x01,0x40; 0x06:0x02,0x41.

- Reset, run = 1 for one cycle, inst_ready = 1 → inst_out sequence 0x3112, 0x3413, 0x0140, 0x0241 with inst_pc 0,2,4,6 on consecutive cycles; retired = 4 after the fourth.
- inst_ready = 0 for 3 cycles after the first capture → inst_out stays 0x3112, inst_pc 0, imem_addr 2. After release the next value is 0x3413, no skip.
- Redirect to 0x05 while inst_valid = 1 (0x3413) → next cycle inst_valid = 0, imem_addr = 0x04. The following cycle gives inst_out 0x0140, inst_pc 4.
- halt_req with inst_valid = 1, inst_ready = 0 for 2 cycles, then 1 → state DRAIN, retired +1, halted = 1. imem_addr frozen; redirect to 0x06 restarts with 0x0241.
- ADDR_W = 8, redirect to 0xFE, inst_ready = 1 → captures at 0xFE then pc wraps to 0x00; inst_pc 0x00 gives 0x3112.
- Assert reset asynchronously mid-stream → inst_valid, busy, retired, imem_addr return to 0 before the next clk edge; no fetch until run.
